// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST driver.
// Build option: ALU_BIST_MODEL_EN adds the reference-model mismatch counter.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT,
        DONE
    } state_e;

    localparam int NUM_OPS = 5;
    localparam alu_op_e OP_TABLE [NUM_OPS] = '{
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT
    };

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    // Bits 31, 21, 1 and 0 feed the MISR shift-in bit.
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
    localparam logic [31:0] OPB_XOR   = 32'h5A5A_5A5A;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] operand_b(input logic [31:0] s);
        return {s[18:0], s[31:19]} ^ OPB_XOR;
    endfunction

    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] res,
        input logic        zero
    );
        return {sig[30:0], ^(sig & MISR_TAPS)} ^ res ^ {31'b0, zero};
    endfunction

endpackage

// File: rtl/alu_bist_driver_ref.sv
// Combinational golden ALU used to cross-check the real ALU.
// Instantiated only when ALU_BIST_MODEL_EN is defined.
module alu_ref_model
    import alu_bist_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    logic [31:0] diff;
    logic        ovf;

    always_comb begin
        diff     = a_i + ~b_i + 32'd1;
        // Signed overflow of A-B: operands differ in sign and result flips.
        ovf      = (a_i[31] ^ b_i[31]) & (a_i[31] ^ diff[31]);
        result_o = '0;
        unique case (ctrl_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = diff;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_SLT:  result_o = {31'b0, ovf ^ diff[31]};
            default: result_o = '0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/alu_bist_driver.sv
// BIST initiator: drives LFSR operands into the ALU and folds responses into a MISR.
// Build option: ALU_BIST_MODEL_EN enables the reference-model mismatch counter.
module alu_bist_driver
    import alu_bist_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234,
    parameter int          LAT         = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] golden_sig,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [15:0] mismatch_cnt
);

    localparam logic [15:0] NV     = 16'(NUM_VECTORS);
    localparam logic [15:0] LAT_M1 = 16'((LAT > 0) ? LAT - 1 : 0);

    state_e      state_q, state_d;
    alu_op_e     ctrl_q, ctrl_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_nx;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] sig_q, sig_d;
    logic [15:0] idx_q, idx_d, wcnt_q, wcnt_d;
    logic [15:0] mm_q, mm_d;
    logic [2:0]  op_sel_q, op_sel_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic        launch, capture, mm_hit;

`ifdef ALU_BIST_MODEL_EN
    logic [31:0] ref_res;
    logic        ref_zero;

    alu_ref_model u_ref (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (ctrl_q),
        .result_o (ref_res),
        .zero_o   (ref_zero)
    );

    assign mm_hit = (ref_res != alu_result) || (ref_zero != alu_zero);
`else
    assign mm_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        lfsr_d   = lfsr_q;
        a_d      = a_q;
        b_d      = b_q;
        sig_d    = sig_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        mm_d     = mm_q;
        op_sel_d = op_sel_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        launch   = 1'b0;
        capture  = 1'b0;
        lfsr_nx  = lfsr_step(lfsr_q);

        unique case (state_q)
            IDLE:  launch = start;
            DRIVE: begin
                if (LAT == 0) begin
                    capture = 1'b1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (wcnt_q == LAT_M1) capture = 1'b1;
                else                  wcnt_d  = wcnt_q + 16'd1;
            end
            DONE: begin
                // First DONE cycle is the evaluation edge; later ones accept restarts.
                if (!done_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (sig_q == golden_sig) && (mm_q == 16'd0);
                end else begin
                    launch = start;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d  = DRIVE;
            lfsr_d   = LFSR_SEED;
            a_d      = LFSR_SEED;
            b_d      = operand_b(LFSR_SEED);
            ctrl_d   = OP_TABLE[0];
            op_sel_d = '0;
            sig_d    = '0;
            mm_d     = '0;
            idx_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
        end

        if (capture) begin
            sig_d  = misr_step(sig_q, alu_result, alu_zero);
            lfsr_d = lfsr_nx;
            idx_d  = idx_q + 16'd1;
            if (mm_hit && (mm_q != 16'hFFFF)) mm_d = mm_q + 16'd1;
            if (idx_d == NV) begin
                state_d = DONE;
            end else begin
                state_d  = DRIVE;
                op_sel_d = (op_sel_q == 3'(NUM_OPS - 1)) ? 3'd0 : op_sel_q + 3'd1;
                a_d      = lfsr_nx;
                b_d      = operand_b(lfsr_nx);
                ctrl_d   = OP_TABLE[op_sel_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= OP_ADD;
            lfsr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sig_q    <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            mm_q     <= '0;
            op_sel_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            lfsr_q   <= lfsr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sig_q    <= sig_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            mm_q     <= mm_d;
            op_sel_q <= op_sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_ctrl     = ctrl_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign signature    = sig_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Scoreboard bench for alu_bist_driver: nominal, fault, busy-start,
// mid-run reset, latency-2 and slt-overflow runs.
module tb_alu_bist_driver;

    localparam logic [31:0] SEED0 = 32'hACE1_1234;
    localparam logic [31:0] TAPS  = 32'h8020_0003;
`ifdef ALU_BIST_MODEL_EN
    localparam int MM_FAULT = 1;
`else
    localparam int MM_FAULT = 0;
`endif

    function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ TAPS;
        return r;
    endfunction

    // Walk the LFSR backwards so a chosen value appears on a given vector.
    function automatic logic [31:0] back_seed(input logic [31:0] s, input int n);
        logic [31:0] v;
        logic [31:0] t;
        v = s;
        for (int i = 0; i < n; i++) begin
            if (v[31]) begin
                t = v ^ TAPS;
                v = {t[30:0], 1'b1};
            end else begin
                v = {v[30:0], 1'b0};
            end
        end
        return v;
    endfunction

    localparam logic [31:0] SEED2 = back_seed(32'h8000_0000, 4);

    function automatic logic [31:0] opb(input logic [31:0] a);
        return {a[18:0], a[31:19]} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [2:0] op_of(input int k);
        case (k % 5)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        case (c)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n,
                                              input int fault);
        logic [31:0] s, sig, r;
        logic z, fb;
        s = seed;
        sig = '0;
        for (int k = 0; k < n; k++) begin
            r = alu_fn(s, opb(s), op_of(k));
            z = (r == 32'd0);
            if (k == fault) r[0] = ~r[0];
            fb = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
            sig = {sig[30:0], fb} ^ r ^ {31'b0, z};
            s = lfsr_nx(s);
        end
        return sig;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instance 0: default parameters, combinational ALU with fault injection.
    logic        start0 = 1'b0, flip0 = 1'b0, zero0, busy0, done0, pass0;
    logic [31:0] golden0 = '0, res0, res0_ok, a0, b0, sig0;
    logic [2:0]  ctrl0;
    logic [15:0] mm0;
    assign res0_ok = alu_fn(a0, b0, ctrl0);
    assign res0    = res0_ok ^ {31'b0, flip0};
    assign zero0   = (res0_ok == 32'd0);

    alu_bist_driver u0 (
        .clk(clk), .reset(rst), .start(start0), .golden_sig(golden0),
        .alu_result(res0), .alu_zero(zero0), .alu_a(a0), .alu_b(b0),
        .alu_ctrl(ctrl0), .busy(busy0), .done(done0), .pass(pass0),
        .signature(sig0), .mismatch_cnt(mm0)
    );

    // Instance 1: two-stage pipelined ALU.
    logic        start1 = 1'b0, zero1, busy1, done1, pass1;
    logic [31:0] golden1 = '0, res1, a1, b1, sig1, p1, p2;
    logic [2:0]  ctrl1;
    logic [15:0] mm1;
    always_ff @(posedge clk) begin
        p1 <= alu_fn(a1, b1, ctrl1);
        p2 <= p1;
    end
    assign res1  = p2;
    assign zero1 = (p2 == 32'd0);

    alu_bist_driver #(.NUM_VECTORS(4), .LAT(2)) u1 (
        .clk(clk), .reset(rst), .start(start1), .golden_sig(golden1),
        .alu_result(res1), .alu_zero(zero1), .alu_a(a1), .alu_b(b1),
        .alu_ctrl(ctrl1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .mismatch_cnt(mm1)
    );

    // Instance 2: seed chosen so vector 4 is slt with A = 0x8000_0000.
    logic        start2 = 1'b0, zero2, busy2, done2, pass2;
    logic [31:0] golden2 = '0, res2, a2, b2, sig2;
    logic [2:0]  ctrl2;
    logic [15:0] mm2;
    assign res2  = alu_fn(a2, b2, ctrl2);
    assign zero2 = (res2 == 32'd0);

    alu_bist_driver #(.NUM_VECTORS(5), .LFSR_SEED(SEED2)) u2 (
        .clk(clk), .reset(rst), .start(start2), .golden_sig(golden2),
        .alu_result(res2), .alu_zero(zero2), .alu_a(a2), .alu_b(b2),
        .alu_ctrl(ctrl2), .busy(busy2), .done(done2), .pass(pass2),
        .signature(sig2), .mismatch_cnt(mm2)
    );

    logic [95:0] sb[$];

    task automatic push_run(input logic [31:0] seed, input int n, input int rep);
        logic [31:0] s;
        sb.delete();
        s = seed;
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < rep; r++) sb.push_back({29'b0, op_of(k), opb(s), s});
            s = lfsr_nx(s);
        end
    endtask

    // Entered and left at a falling edge; c counts rising edges since the start edge.
    task automatic run0(input int fv, input int sat, input int rat, output int dcyc);
        logic [95:0] e;
        push_run(SEED0, 256, 1);
        dcyc = -1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done0) begin
                dcyc = c;
                break;
            end
            if (c == rat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                dcyc = -2;
                break;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("vec0", {29'b0, ctrl0, b0, a0}, e);
            end
            flip0  = (c == fv);
            start0 = (c == sat);
            @(negedge clk);
        end
        flip0  = 1'b0;
        start0 = 1'b0;
    endtask

    logic [31:0] g_nom, g_flt;
    int d;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a", a0, 0);
        chk("rst_b", b0, 0);
        chk("rst_ctrl", ctrl0, 0);
        chk("rst_flags", {busy0, done0, pass0}, 0);
        chk("rst_sig", sig0, 0);
        chk("rst_mm", mm0, 0);
        rst = 1'b0;
        @(negedge clk);

        g_nom = model_sig(SEED0, 256, -1);
        g_flt = model_sig(SEED0, 256, 3);

        golden0 = g_nom;
        run0(-1, -1, -1, d);
        chk("nom_done_cyc", d, 257);
        chk("nom_sig", sig0, g_nom);
        chk("nom_pass", pass0, 1);
        chk("nom_busy", busy0, 0);
        chk("nom_mm", mm0, 0);

        run0(3, -1, -1, d);
        chk("flt_done_cyc", d, 257);
        chk("flt_sig", sig0, g_flt);
        chk("flt_pass", pass0, 0);
        chk("flt_mm", mm0, MM_FAULT);

        run0(-1, 20, -1, d);
        chk("bsy_done_cyc", d, 257);
        chk("bsy_sig", sig0, g_nom);
        chk("bsy_pass", pass0, 1);

        run0(-1, -1, 10, d);
        chk("mrst_a", a0, 0);
        chk("mrst_b", b0, 0);
        chk("mrst_ctrl", ctrl0, 0);
        chk("mrst_flags", {busy0, done0, pass0}, 0);
        chk("mrst_sig", sig0, 0);
        chk("mrst_mm", mm0, 0);
        repeat (3) @(negedge clk);
        chk("mrst_idle", {busy0, done0, sig0, a0}, 0);
        run0(-1, -1, -1, d);
        chk("rerun_done_cyc", d, 257);
        chk("rerun_sig", sig0, g_nom);
        chk("rerun_pass", pass0, 1);

        // Latency-2 run: each vector held three cycles.
        golden1 = model_sig(SEED0, 4, -1);
        push_run(SEED0, 4, 3);
        d = -1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done1) begin
                d = c;
                break;
            end
            if (sb.size() > 0) chk("vec1", {29'b0, ctrl1, b1, a1}, sb.pop_front());
            @(negedge clk);
        end
        chk("lat_done_cyc", d, 13);
        chk("lat_sig", sig1, golden1);
        chk("lat_pass", pass1, 1);
        chk("lat_mm", mm1, 0);

        // Slt overflow vector: A negative, B positive, A-B overflows.
        golden2 = model_sig(SEED2, 5, -1);
        d = -1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done2) begin
                d = c;
                break;
            end
            if (c == 4) begin
                chk("slt_a", a2, 32'h8000_0000);
                chk("slt_b", b2, 32'h5A5A_4A5A);
                chk("slt_ctrl", ctrl2, 3'b101);
            end
            @(negedge clk);
        end
        chk("slt_done_cyc", d, 6);
        chk("slt_mm", mm2, 0);
        chk("slt_sig", sig2, golden2);
        chk("slt_pass", pass2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
